// File: rtl/router_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | router_pkg : shared constants for the 1x3 router datapath and its FIFOs   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package router_pkg;

   localparam int DATA_W     = 8;
   localparam int FIFO_DEPTH = 16;
   localparam int FIFO_PTR_W = 4;

   // Header byte layout: [7:2] payload length, [1:0] destination address
   localparam int HDR_LEN_MSB  = 7;
   localparam int HDR_LEN_LSB  = 2;
   localparam int HDR_ADDR_MSB = 1;
   localparam int HDR_ADDR_LSB = 0;

   localparam logic [DATA_W-1:0] IDLE_DATA = 8'h00;

endpackage
`default_nettype wire

// File: rtl/router_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | router_fifo_if : write/read strobes, data and status of one output FIFO   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface router_fifo_if #(
   parameter int DATA_W = router_pkg::DATA_W
);

   logic              soft_reset;
   logic              write_enb;
   logic              read_enb;
   logic              lfd_state;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              full;
   logic              empty;
   logic              pkt_busy;

   modport master (
      output soft_reset, write_enb, read_enb, lfd_state, data_in,
      input  data_out, full, empty, pkt_busy
   );

   modport slave (
      input  soft_reset, write_enb, read_enb, lfd_state, data_in,
      output data_out, full, empty, pkt_busy
   );

endinterface
`default_nettype wire

// File: rtl/router_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | router_fifo : per-destination output FIFO with header tag and packet     |
// |               byte counter. Rev 1.0                                      |
// +--------------------------------------------------------------------------+
module router_fifo #(
   parameter int DATA_W = router_pkg::DATA_W,
   parameter int DEPTH  = router_pkg::FIFO_DEPTH,
   parameter int PTR_W  = router_pkg::FIFO_PTR_W
) (
   input  wire           clock,
   input  wire           resetn,
   router_fifo_if.slave  bus
);

   import router_pkg::*;

   localparam int c_ENTRY_W = DATA_W + 1;
   localparam int c_CNT_W   = 7;
   localparam int c_LEN_W   = HDR_LEN_MSB - HDR_LEN_LSB + 1;

   logic [c_ENTRY_W-1:0] r_mem [DEPTH];
   logic [PTR_W:0]       r_wr_ptr;
   logic [PTR_W:0]       r_rd_ptr;
   logic [c_CNT_W-1:0]   r_count;
   logic                 r_lfd_d;
   logic [DATA_W-1:0]    r_data_out;

   logic                 w_full;
   logic                 w_empty;
   logic                 w_do_write;
   logic                 w_do_read;
   logic [c_ENTRY_W-1:0] w_rd_entry;
   logic [c_LEN_W-1:0]   w_hdr_len;

   assign w_full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_do_write = bus.write_enb & ~w_full  & ~bus.soft_reset;
   assign w_do_read  = bus.read_enb  & ~w_empty & ~bus.soft_reset;
   assign w_rd_entry = r_mem[r_rd_ptr[PTR_W-1:0]];
   assign w_hdr_len  = w_rd_entry[HDR_LEN_MSB:HDR_LEN_LSB];

   // Storage is deliberately not reset; the empty flag guards every read.
   always_ff @(posedge clock) begin
      if (w_do_write) begin
         r_mem[r_wr_ptr[PTR_W-1:0]] <= {r_lfd_d, bus.data_in};
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_lfd_d    <= 1'b0;
         r_data_out <= DATA_W'(IDLE_DATA);
      end else begin
         // The register stage lags the FSM by a cycle, so the tag is delayed to match.
         r_lfd_d <= bus.lfd_state;
         if (bus.soft_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= DATA_W'(IDLE_DATA);
         end else begin
            if (w_do_write) begin
               r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            end
            if (w_do_read) begin
               r_rd_ptr   <= r_rd_ptr + (PTR_W+1)'(1);
               r_data_out <= w_rd_entry[DATA_W-1:0];
               if (w_rd_entry[DATA_W]) begin
                  // Payload length plus the trailing parity byte
                  r_count <= c_CNT_W'(w_hdr_len) + c_CNT_W'(1);
               end else if (r_count != '0) begin
                  r_count <= r_count - c_CNT_W'(1);
               end
            end else if ((r_count == '0) && w_empty && !bus.read_enb) begin
               r_data_out <= DATA_W'(IDLE_DATA);
            end
         end
      end
   end

   assign bus.data_out = r_data_out;
   assign bus.full     = w_full;
   assign bus.empty    = w_empty;
   assign bus.pkt_busy = (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_router_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_router_fifo : scoreboard bench for router_fifo. Rev 1.0               |
// +--------------------------------------------------------------------------+
module tb_router_fifo;

   logic clock  = 1'b0;
   logic resetn = 1'b0;

   int vectors     = 0;
   int miscompares = 0;

   // Reference state: queue of {tag, byte}, byte counter, delayed lfd, expected data_out
   logic [8:0] sb_q [$];
   logic [6:0] m_cnt  = '0;
   logic       m_lfd_d = 1'b0;
   logic [7:0] m_dout = '0;

   router_fifo_if bus ();

   router_fifo dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   task automatic set_in(input logic we, input logic re, input logic lfd,
                         input logic [7:0] din, input logic sr);
      bus.write_enb  = we;
      bus.read_enb   = re;
      bus.lfd_state  = lfd;
      bus.data_in    = din;
      bus.soft_reset = sr;
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_cnt   = '0;
      m_lfd_d = 1'b0;
      m_dout  = '0;
   endtask

   // Advance one clock, updating the reference from the inputs sampled at that edge.
   task automatic tick();
      logic       full_b;
      logic       empty_b;
      logic [8:0] e;
      full_b  = (sb_q.size() == 16);
      empty_b = (sb_q.size() == 0);
      if (bus.soft_reset) begin
         sb_q.delete();
         m_cnt  = '0;
         m_dout = '0;
      end else begin
         if (bus.read_enb && !empty_b) begin
            e      = sb_q.pop_front();
            m_dout = e[7:0];
            if (e[8])               m_cnt = 7'(e[7:2]) + 7'd1;
            else if (m_cnt != 7'd0) m_cnt = m_cnt - 7'd1;
         end else if (m_cnt == 7'd0 && empty_b && !bus.read_enb) begin
            m_dout = 8'h00;
         end
         if (bus.write_enb && !full_b) sb_q.push_back({m_lfd_d, bus.data_in});
      end
      m_lfd_d = bus.lfd_state;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      set_in(0, 0, 0, 8'h00, 0);
      resetn = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      resetn = 1'b1;
      tick();
      vectors++;
      if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
      vectors++;
      if (bus.full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b expected 0", bus.full); end
      vectors++;
      if (bus.data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data_out: got %h expected 00", bus.data_out); end
      vectors++;
      if (bus.pkt_busy !== 1'b0) begin miscompares++; $display("FAIL reset_pkt_busy: got %b expected 0", bus.pkt_busy); end
   endtask

   task automatic test_packet();
      logic [7:0] pkt [5];
      pkt[0] = 8'h0D;
      pkt[1] = 8'hA1;
      pkt[2] = 8'hB2;
      pkt[3] = 8'hC3;
      pkt[4] = pkt[0] ^ pkt[1] ^ pkt[2] ^ pkt[3];
      set_in(0, 0, 1, 8'h00, 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         set_in(1, 0, 0, pkt[i], 0);
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         set_in(0, 1, 0, 8'h00, 0);
         tick();
         vectors++;
         if (bus.data_out !== pkt[i] || bus.data_out !== m_dout) begin
            miscompares++;
            $display("FAIL pkt_data[%0d]: got %h expected %h", i, bus.data_out, pkt[i]);
         end
         vectors++;
         if (bus.pkt_busy !== 1'(i < 4) || bus.pkt_busy !== (m_cnt != 7'd0)) begin
            miscompares++;
            $display("FAIL pkt_busy[%0d]: got %b expected %b", i, bus.pkt_busy, 1'(i < 4));
         end
      end
      set_in(0, 0, 0, 8'h00, 0);
      tick();
      vectors++;
      if (bus.data_out !== 8'h00) begin miscompares++; $display("FAIL pkt_idle: got %h expected 00", bus.data_out); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 16; i++) begin
         set_in(1, 0, 0, 8'h40 + 8'(i), 0);
         tick();
         vectors++;
         if (bus.full !== 1'(i == 15)) begin
            miscompares++;
            $display("FAIL full_fill[%0d]: got %b expected %b", i, bus.full, 1'(i == 15));
         end
      end
      set_in(1, 0, 0, 8'hEE, 0);
      tick();
      vectors++;
      if (bus.full !== 1'b1) begin miscompares++; $display("FAIL full_overflow: got %b expected 1", bus.full); end
      for (int i = 0; i < 16; i++) begin
         set_in(0, 1, 0, 8'h00, 0);
         tick();
         vectors++;
         if (bus.data_out !== 8'h40 + 8'(i) || bus.data_out !== m_dout) begin
            miscompares++;
            $display("FAIL full_drain[%0d]: got %h expected %h", i, bus.data_out, 8'h40 + 8'(i));
         end
      end
      vectors++;
      if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL full_drained_empty: got %b expected 1", bus.empty); end
      set_in(0, 0, 0, 8'h00, 0);
      tick();
   endtask

   task automatic test_full_rw();
      logic [7:0] exp;
      for (int i = 0; i < 16; i++) begin
         set_in(1, 0, 0, 8'h80 + 8'(i), 0);
         tick();
      end
      set_in(1, 1, 0, 8'hAA, 0);
      tick();
      vectors++;
      if (bus.data_out !== 8'h80) begin miscompares++; $display("FAIL full_rw_read: got %h expected 80", bus.data_out); end
      vectors++;
      if (bus.full !== 1'b0) begin miscompares++; $display("FAIL full_rw_full: got %b expected 0", bus.full); end
      set_in(1, 0, 0, 8'h55, 0);
      tick();
      vectors++;
      if (bus.full !== 1'b1) begin miscompares++; $display("FAIL wrap_write_full: got %b expected 1", bus.full); end
      for (int i = 0; i < 16; i++) begin
         exp = (i < 15) ? 8'h81 + 8'(i) : 8'h55;
         set_in(0, 1, 0, 8'h00, 0);
         tick();
         vectors++;
         if (bus.data_out !== exp || bus.data_out !== m_dout) begin
            miscompares++;
            $display("FAIL wrap_drain[%0d]: got %h expected %h", i, bus.data_out, exp);
         end
      end
      set_in(0, 0, 0, 8'h00, 0);
      tick();
   endtask

   task automatic test_empty_rw();
      set_in(0, 0, 1, 8'h00, 0);
      tick();
      set_in(1, 0, 0, 8'h0D, 0);
      tick();
      set_in(0, 1, 0, 8'h00, 0);
      tick();
      vectors++;
      if (bus.data_out !== 8'h0D || bus.pkt_busy !== 1'b1 || bus.empty !== 1'b1) begin
         miscompares++;
         $display("FAIL empty_rw_setup: got dout=%h busy=%b empty=%b expected 0d 1 1",
                  bus.data_out, bus.pkt_busy, bus.empty);
      end
      set_in(1, 1, 0, 8'h21, 0);
      tick();
      vectors++;
      if (bus.data_out !== 8'h0D || bus.data_out !== m_dout) begin
         miscompares++;
         $display("FAIL empty_rw_hold: got %h expected 0d", bus.data_out);
      end
      vectors++;
      if (bus.empty !== 1'b0) begin miscompares++; $display("FAIL empty_rw_stored: got %b expected 0", bus.empty); end
   endtask

   task automatic test_soft_reset();
      set_in(1, 1, 0, 8'h22, 0);
      tick();
      vectors++;
      if (bus.data_out !== 8'h21 || bus.pkt_busy !== 1'b1 || m_cnt !== 7'd3) begin
         miscompares++;
         $display("FAIL soft_setup: got dout=%h busy=%b expected 21 1", bus.data_out, bus.pkt_busy);
      end
      set_in(0, 1, 0, 8'h00, 1);
      tick();
      vectors++;
      if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL soft_empty: got %b expected 1", bus.empty); end
      vectors++;
      if (bus.pkt_busy !== 1'b0) begin miscompares++; $display("FAIL soft_busy: got %b expected 0", bus.pkt_busy); end
      vectors++;
      if (bus.data_out !== 8'h00) begin miscompares++; $display("FAIL soft_data_out: got %h expected 00", bus.data_out); end
      set_in(0, 0, 0, 8'h00, 0);
      tick();
   endtask

   task automatic test_async_reset();
      set_in(0, 0, 1, 8'h00, 0);
      tick();
      set_in(1, 0, 0, 8'h09, 0);
      tick();
      set_in(1, 1, 0, 8'h31, 0);
      tick();
      vectors++;
      if (bus.data_out !== 8'h09 || bus.pkt_busy !== 1'b1 || bus.empty !== 1'b0) begin
         miscompares++;
         $display("FAIL async_setup: got dout=%h busy=%b empty=%b expected 09 1 0",
                  bus.data_out, bus.pkt_busy, bus.empty);
      end
      set_in(1, 0, 0, 8'h33, 0);
      #2;
      resetn = 1'b0;
      #1;
      model_reset();
      vectors++;
      if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL async_empty: got %b expected 1", bus.empty); end
      vectors++;
      if (bus.pkt_busy !== 1'b0) begin miscompares++; $display("FAIL async_busy: got %b expected 0", bus.pkt_busy); end
      vectors++;
      if (bus.data_out !== 8'h00) begin miscompares++; $display("FAIL async_data_out: got %h expected 00", bus.data_out); end
      #1;
      resetn = 1'b1;
      set_in(0, 0, 0, 8'h00, 0);
      tick();
      vectors++;
      if (bus.empty !== 1'b1 || bus.data_out !== m_dout) begin
         miscompares++;
         $display("FAIL async_after: got empty=%b dout=%h expected 1 00", bus.empty, bus.data_out);
      end
   endtask

   initial begin
      set_in(0, 0, 0, 8'h00, 0);
      test_reset();
      test_packet();
      test_full();
      test_full_rw();
      test_empty_rw();
      test_soft_reset();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
